// File: rtl/cmp_share_arbiter_if.sv
// Handshake bundle between the compare clients / result consumer and the
// shared comparator arbiter. "slave" is the arbiter side, "master" the
// client/consumer side.
interface cmp_share_arbiter_if #(
  parameter int N       = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*N-1:0] a_in;
  logic [NUM_REQ*N-1:0] b_in;
  logic [NUM_REQ-1:0]   gnt;
  logic                 res_valid;
  logic                 res_ready;
  logic [ID_W-1:0]      res_id;
  logic                 res_smaller;
  logic                 res_equal;
  logic                 res_bigger;

  modport master (
    output req, a_in, b_in, res_ready,
    input  gnt, res_valid, res_id, res_smaller, res_equal, res_bigger
  );

  modport slave (
    input  req, a_in, b_in, res_ready,
    output gnt, res_valid, res_id, res_smaller, res_equal, res_bigger
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter plus two-stage pipeline sharing one N-bit magnitude
// comparator among NUM_REQ requesters. Stage 1 grants and captures one
// operand pair per cycle; stage 2 registers a one-hot smaller/equal/bigger
// result behind a valid/ready handshake.
// Optional feature: define CMP_SIGNED_EN to compare the captured operands as
// two's-complement values (arbitration and timing unchanged); default build
// compares unsigned.
module cmp_share_arbiter #(
  parameter int N       = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  cmp_share_arbiter_if.slave      bus
);

  logic [NUM_REQ-1:0] gnt_q;
  logic [ID_W-1:0]    ptr;
  logic               s1_v;
  logic [ID_W-1:0]    s1_id;
  logic [N-1:0]       s1_a;
  logic [N-1:0]       s1_b;

  logic               res_valid_q;
  logic [ID_W-1:0]    res_id_q;
  logic               res_smaller_q;
  logic               res_equal_q;
  logic               res_bigger_q;

  logic [NUM_REQ-1:0] elig;
  logic               stall;
  logic               found;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    ptr_next;
  logic               lt;
  logic               eq;
  logic               gt;

  // A requester whose grant is still high is excluded, so a held req is not
  // captured twice; the pipeline stalls only when both stages are full.
  assign elig  = bus.req & ~gnt_q;
  assign stall = s1_v & res_valid_q & ~bus.res_ready;

  // Round-robin search: first eligible requester at or above ptr, wrapping.
  always_comb begin : arb_search
    int idx;
    // NOTE: every variable gets a default before any conditional write so no
    // latch is inferred when no requester is eligible.
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    ptr_next = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end

  // Shared comparator on the captured operand pair.
  always_comb begin
`ifdef CMP_SIGNED_EN
    lt = $signed(s1_a) < $signed(s1_b);
`else
    lt = s1_a < s1_b;
`endif
    eq = (s1_a == s1_b);
    gt = ~lt & ~eq;
  end

  // Stage 1: grant the winner, capture its operands, advance the pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the operand/id capture registers are reset too; they are few
      // bits and a clean reset state keeps the datapath deterministic.
      gnt_q <= '0;
      ptr   <= '0;
      s1_v  <= 1'b0;
      s1_id <= '0;
      s1_a  <= '0;
      s1_b  <= '0;
    end else if (stall) begin
      gnt_q <= '0;
    end else if (found) begin
      gnt_q <= NUM_REQ'(1) << win;
      ptr   <= ptr_next;
      s1_v  <= 1'b1;
      s1_id <= win;
      s1_a  <= bus.a_in[int'(win)*N +: N];
      s1_b  <= bus.b_in[int'(win)*N +: N];
    end else begin
      gnt_q <= '0;
      s1_v  <= 1'b0;
    end
  end

  // Stage 2: load the result register whenever it is empty or being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_smaller_q <= 1'b0;
      res_equal_q   <= 1'b0;
      res_bigger_q  <= 1'b0;
    end else if (~res_valid_q | bus.res_ready) begin
      res_valid_q   <= s1_v;
      if (s1_v) begin
        res_id_q <= s1_id;
      end
      res_smaller_q <= s1_v & lt;
      res_equal_q   <= s1_v & eq;
      res_bigger_q  <= s1_v & gt;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_id      = res_id_q;
  assign bus.res_smaller = res_smaller_q;
  assign bus.res_equal   = res_equal_q;
  assign bus.res_bigger  = res_bigger_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed testbench for cmp_share_arbiter (N=8, NUM_REQ=4). Expected values
// are hand-derived; result vectors are packed as {valid, id[1:0], smaller,
// equal, bigger}.
module tb_cmp_share_arbiter;

  localparam int N       = 8;
  localparam int NUM_REQ = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  cmp_share_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ)) bus ();

  cmp_share_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [5:0] res_obs = {bus.res_valid, bus.res_id,
                        bus.res_smaller, bus.res_equal, bus.res_bigger};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.a_in[i*N +: N] = a;
    bus.b_in[i*N +: N] = b;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req       = '0;
    bus.res_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req       = 4'hF;
    bus.res_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'(i), 8'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({bus.gnt, res_obs} !== 10'd0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: got gnt=%b res=%b expected all zero", c, bus.gnt, res_obs);
      end
    end
    rst = 1'b0;
    step();
    tests++;
    if (bus.gnt !== 4'b0001) begin
      fails++;
      $display("FAIL reset_first_grant: got %b expected 0001", bus.gnt);
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_op(2, 8'd4, 8'd4);
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    tests++;
    if ({bus.gnt, res_obs} !== 10'd0) begin
      fails++;
      $display("FAIL reset_mid_discard: got gnt=%b res=%b expected all zero", bus.gnt, res_obs);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_op(0, 8'd5, 8'd9);
    bus.req = 4'b0001;
    step();
    tests++;
    if (bus.gnt !== 4'b0001) begin
      fails++;
      $display("FAIL single_gnt: got %b expected 0001", bus.gnt);
    end
    bus.req = 4'b0000;
    step();
    tests++;
    if ({bus.gnt, res_obs} !== {4'b0000, 6'b1_00_100}) begin
      fails++;
      $display("FAIL single_result: got gnt=%b res=%b expected 0000/100100", bus.gnt, res_obs);
    end
    step();
    tests++;
    if (res_obs !== 6'b0_00_000) begin
      fails++;
      $display("FAIL single_drain: got %b expected 000000", res_obs);
    end
    // Held request: grant only every second cycle.
    bus.req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (bus.gnt !== ((c == 1) ? 4'b0000 : 4'b0001)) begin
        fails++;
        $display("FAIL single_held cyc%0d: got %b expected %b", c, bus.gnt,
                 (c == 1) ? 4'b0000 : 4'b0001);
      end
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    logic [5:0] exp_res [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_res = '{6'b0_00_000, 6'b1_00_100, 6'b1_01_100, 6'b1_10_010, 6'b1_11_001};
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'(i), 8'd2);
    bus.req = 4'hF;
    for (int c = 0; c < 5; c++) begin
      step();
      tests++;
      if ({bus.gnt, res_obs} !== {exp_gnt[c], exp_res[c]}) begin
        fails++;
        $display("FAIL rr cyc%0d: got gnt=%b res=%b expected %b/%b", c, bus.gnt, res_obs,
                 exp_gnt[c], exp_res[c]);
      end
    end
    bus.req = 4'b0000;
    step();
    step();
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    set_op(0, 8'd1, 8'd1);
    set_op(3, 8'd7, 8'd1);
    bus.req = 4'b1000;
    step();
    tests++;
    if (bus.gnt !== 4'b1000) begin
      fails++;
      $display("FAIL wrap_pre: got %b expected 1000", bus.gnt);
    end
    bus.req = 4'b0000;
    step();
    step();
    bus.req = 4'b1001;
    step();
    tests++;
    if (bus.gnt !== 4'b0001) begin
      fails++;
      $display("FAIL wrap_first: got %b expected 0001", bus.gnt);
    end
    bus.req = 4'b1000;
    step();
    tests++;
    if ({bus.gnt, res_obs} !== {4'b1000, 6'b1_00_010}) begin
      fails++;
      $display("FAIL wrap_second: got gnt=%b res=%b expected 1000/100010", bus.gnt, res_obs);
    end
    bus.req = 4'b0000;
    step();
    tests++;
    if (res_obs !== 6'b1_11_001) begin
      fails++;
      $display("FAIL wrap_result3: got %b expected 111001", res_obs);
    end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_op(0, 8'd3, 8'd7);
    set_op(1, 8'd9, 8'd4);
    set_op(2, 8'd5, 8'd5);
    bus.res_ready = 1'b0;
    bus.req       = 4'b0011;
    step();
    tests++;
    if (bus.gnt !== 4'b0001) begin
      fails++;
      $display("FAIL bp_gnt0: got %b expected 0001", bus.gnt);
    end
    bus.req = 4'b0010;
    step();
    tests++;
    if ({bus.gnt, res_obs} !== {4'b0010, 6'b1_00_100}) begin
      fails++;
      $display("FAIL bp_gnt1: got gnt=%b res=%b expected 0010/100100", bus.gnt, res_obs);
    end
    // Requester 2 waits while both stages are full.
    bus.req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({bus.gnt, res_obs} !== {4'b0000, 6'b1_00_100}) begin
        fails++;
        $display("FAIL bp_stall cyc%0d: got gnt=%b res=%b expected 0000/100100", c, bus.gnt, res_obs);
      end
    end
    bus.res_ready = 1'b1;
    step();
    tests++;
    if ({bus.gnt, res_obs} !== {4'b0100, 6'b1_01_001}) begin
      fails++;
      $display("FAIL bp_release: got gnt=%b res=%b expected 0100/101001", bus.gnt, res_obs);
    end
    bus.req = 4'b0000;
    step();
    tests++;
    if (res_obs !== 6'b1_10_010) begin
      fails++;
      $display("FAIL bp_third: got %b expected 110010", res_obs);
    end
    step();
    tests++;
    if (res_obs !== 6'b0_10_000) begin
      fails++;
      $display("FAIL bp_drain: got %b expected 010000", res_obs);
    end
  endtask

  task automatic test_signed();
    logic [2:0] exp_ff;
`ifdef CMP_SIGNED_EN
    exp_ff = 3'b100;
`else
    exp_ff = 3'b001;
`endif
    do_reset();
    set_op(0, 8'hFF, 8'h01);
    bus.req = 4'b0001;
    step();
    bus.req = 4'b0000;
    step();
    tests++;
    if (res_obs !== {3'b100, exp_ff}) begin
      fails++;
      $display("FAIL signed_ff_01: got %b expected %b", res_obs, {3'b100, exp_ff});
    end
    set_op(0, 8'hAA, 8'hAA);
    bus.req = 4'b0001;
    step();
    bus.req = 4'b0000;
    step();
    tests++;
    if (res_obs !== 6'b1_00_010) begin
      fails++;
      $display("FAIL signed_equal: got %b expected 100010", res_obs);
    end
    step();
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.req       = '0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_reset_mid();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_signed();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
- Round-robin arbiter and two-stage pipeline that shares one N-bit magnitude comparator among NUM_REQ requesters.
- Each requester presents an operand pair with req. The block grants one requester per cycle, captures its operands, compares them, and returns a one-hot smaller/equal/bigger result tagged with the requester id.
- The output side has a valid/ready handshake with backpressure.
- Sits between multiple compare clients and the shared compare datapath.

Parameters:
- N, 8, operand width in bits
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), width of the requester id

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester request; held with operands until gnt seen
- a_in  input  NUM_REQ*N  flattened operand A; requester i uses bits [i*N +: N]
- b_in  input  NUM_REQ*N  flattened operand B, same packing
- gnt  output  NUM_REQ  registered one-hot grant pulse; operands captured at the edge that raised it
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_id  output  ID_W  requester index of the current result
- res_smaller  output  1  a<b
- res_equal  output  1  a==b
- res_bigger  output  1  a>b

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - gnt=0, res_valid=0, res_id=0, all flags 0.
  - Round-robin pointer ptr=0; stage-1 valid s1_v=0.
  - Reset mid-operation discards all in-flight captures and results.
- Eligibility: elig = req & ~gnt. A requester whose gnt is currently high cannot be re-granted at that edge, so a held req does not cause a duplicate capture.
- stall = s1_v & res_valid & ~res_ready.
- Stage 1 (arbitrate/capture), each edge when !stall:
  - If elig != 0: winner = first set bit of elig, searching from ptr upward with wrap at NUM_REQ-1 -> 0.
  - On a winner: latch a/b slice and winner id into s1; s1_v=1; gnt=onehot(winner) for one cycle; ptr=(winner+1) mod NUM_REQ.
  - If elig == 0: s1_v=0, gnt=0, ptr unchanged.
- When stall: gnt=0, s1 and ptr hold, no new capture.
- Stage 2 (compare/output): output register loads from s1 when (~res_valid | res_ready).
  - If s1_v: res_valid=1, res_id=s1 id. Exactly one flag set from the unsigned compare of the captured a and b.
  - Else: res_valid=0 and all flags 0.
- Output hold: while res_valid & ~res_ready, res_valid, res_id and flags hold stable.
- Flags are all 0 whenever res_valid=0.
- Latency: req sampled at edge E0 -> gnt high during the cycle after E0 -> res_valid high after E1. Two edges total with no backpressure.
- Throughput: one result per cycle across distinct requesters. A single continuously requesting client gets at most one grant every 2 cycles.
- Simultaneous events:
  - res_ready with a new s1 in the same cycle: the result is replaced without a bubble.
  - All req high: grants rotate ptr order, one per cycle.
- Requester contract: hold operands stable while req=1 and until gnt is observed. After gnt, drop req or change operands.

Optional Feature:
- Macro CMP_SIGNED_EN.
- Defined: captured operands are compared as two's-complement signed values; arbitration and timing are unchanged.
- Undefined: unsigned compare.

Test Plan:
- Reset check: assert rst 3 cycles with req=4'hF -> gnt=0, res_valid=0, flags=0, no captures; first grant after release goes to requester 0.
- Single request: req=4'b0001, a0=5, b0=9 -> gnt=4'b0001 one cycle; next cycle res_valid=1, res_id=0, res_smaller=1. Second identical request is granted no earlier than 2 cycles after the first.
- Round-robin: all req high continuously; a_i=i, b_i=2 -> grants 0001,0010,0100,1000,0001; results id0 smaller, id1 smaller, id2 equal, id3 bigger, in order.
- Pointer wrap: after a grant to requester 3, assert req[3] and req[0] together -> requester 0 granted first, then 3.
- Backpressure: res_ready=0 for 4 cycles with req0 and req1 pending -> one result held stable, one capture pending, gnt=0 during the stall. Raise res_ready -> both results delivered, no loss or duplication.
- CMP_SIGNED_EN: a=8'hFF, b=8'h01 -> res_bigger=1 without the macro, res_smaller=1 with it. a=b=8'hAA -> res_equal=1 in both builds.
